// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: fixed-latency busy/valid handshake in front of
// a word-addressed array with byte-lane writes and address/command error checks.
module dmem_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_dmem_addr,
   input  logic        i_dmem_ren,
   input  logic        i_dmem_wen,
   input  logic [31:0] i_dmem_wdata,
   input  logic [3:0]  i_dmem_mask,
   output logic        o_dmem_busy,
   output logic        o_dmem_valid,
   output logic [31:0] o_dmem_rdata,
   output logic        o_dmem_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
   localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             accept, access;

   logic [31:0] mem [DEPTH_WORDS];

   logic [31:0] addr_p0, wdata_p0;
   logic [3:0]  mask_p0;
   logic        ren_p0, wen_p0;

   logic [31:0]      addr_s, wdata_s, off_s;
   logic [3:0]       mask_s;
   logic             ren_s, wen_s, err_s;
   logic [IDX_W-1:0] idx_s;

   function automatic logic [31:0] lane_mask(input logic [3:0] m);
      return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
   endfunction

   assign accept      = i_rst_n && (state != WAIT) && (i_dmem_ren || i_dmem_wen);
   assign o_dmem_busy = (state == WAIT);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      access    = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = (LATENCY > 1) ? WAIT : RESP;
               cnt_nxt   = CNT_LOAD;
               access    = (LATENCY == 1);
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               state_nxt = RESP;
               access    = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         RESP: begin
            state_nxt = IDLE;
            if (accept) begin
               state_nxt = (LATENCY > 1) ? WAIT : RESP;
               cnt_nxt   = CNT_LOAD;
               access    = (LATENCY == 1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // p0: request captured at acceptance, used at the access edge when LATENCY > 1
   always_ff @(posedge i_clk) begin
      if (accept) begin
         addr_p0  <= i_dmem_addr;
         wdata_p0 <= i_dmem_wdata;
         mask_p0  <= i_dmem_mask;
         ren_p0   <= i_dmem_ren;
         wen_p0   <= i_dmem_wen;
      end
   end

   // With single-cycle latency the access edge is the acceptance edge itself.
   assign addr_s  = (LATENCY == 1) ? i_dmem_addr  : addr_p0;
   assign wdata_s = (LATENCY == 1) ? i_dmem_wdata : wdata_p0;
   assign mask_s  = (LATENCY == 1) ? i_dmem_mask  : mask_p0;
   assign ren_s   = (LATENCY == 1) ? i_dmem_ren   : ren_p0;
   assign wen_s   = (LATENCY == 1) ? i_dmem_wen   : wen_p0;

   assign off_s = addr_s - BASE_ADDR;
   assign idx_s = off_s[IDX_W+1:2];
   assign err_s = (ren_s && wen_s) || (addr_s[1:0] != 2'b00) ||
                  (addr_s < BASE_ADDR) || (off_s >= SPAN);

   always_ff @(posedge i_clk) begin
      if (access && wen_s && !err_s) begin
         for (int b = 0; b < 4; b++) begin
            if (mask_s[b]) mem[idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
         end
      end
   end

   // p1: registered response, rdata holds between responses
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_dmem_valid <= 1'b0;
         o_dmem_err   <= 1'b0;
         o_dmem_rdata <= '0;
      end else if (access) begin
         o_dmem_valid <= 1'b1;
         o_dmem_err   <= err_s;
         o_dmem_rdata <= (ren_s && !err_s) ? (mem[idx_s] & lane_mask(mask_s)) : '0;
      end else begin
         o_dmem_valid <= 1'b0;
         o_dmem_err   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: four instances at different latencies/bases,
// each checked cycle by cycle against a queue-based reference model.
module tb_dmem_responder;

   localparam int DW = 16;
   localparam int N  = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n [N];
   logic [31:0] addr  [N];
   logic [31:0] wdata [N];
   logic        ren   [N];
   logic        wen   [N];
   logic [3:0]  mask  [N];
   logic        busy  [N];
   logic        valid [N];
   logic        err   [N];
   logic [31:0] rdata [N];

   dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(2), .BASE_ADDR(32'h0)) u0 (
      .i_clk(clk), .i_rst_n(rst_n[0]), .i_dmem_addr(addr[0]), .i_dmem_ren(ren[0]),
      .i_dmem_wen(wen[0]), .i_dmem_wdata(wdata[0]), .i_dmem_mask(mask[0]),
      .o_dmem_busy(busy[0]), .o_dmem_valid(valid[0]), .o_dmem_rdata(rdata[0]), .o_dmem_err(err[0]));
   dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(1), .BASE_ADDR(32'h0)) u1 (
      .i_clk(clk), .i_rst_n(rst_n[1]), .i_dmem_addr(addr[1]), .i_dmem_ren(ren[1]),
      .i_dmem_wen(wen[1]), .i_dmem_wdata(wdata[1]), .i_dmem_mask(mask[1]),
      .o_dmem_busy(busy[1]), .o_dmem_valid(valid[1]), .o_dmem_rdata(rdata[1]), .o_dmem_err(err[1]));
   dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(4), .BASE_ADDR(32'h40)) u2 (
      .i_clk(clk), .i_rst_n(rst_n[2]), .i_dmem_addr(addr[2]), .i_dmem_ren(ren[2]),
      .i_dmem_wen(wen[2]), .i_dmem_wdata(wdata[2]), .i_dmem_mask(mask[2]),
      .o_dmem_busy(busy[2]), .o_dmem_valid(valid[2]), .o_dmem_rdata(rdata[2]), .o_dmem_err(err[2]));
   dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(3), .BASE_ADDR(32'h0)) u3 (
      .i_clk(clk), .i_rst_n(rst_n[3]), .i_dmem_addr(addr[3]), .i_dmem_ren(ren[3]),
      .i_dmem_wen(wen[3]), .i_dmem_wdata(wdata[3]), .i_dmem_mask(mask[3]),
      .o_dmem_busy(busy[3]), .o_dmem_valid(valid[3]), .o_dmem_rdata(rdata[3]), .o_dmem_err(err[3]));

   function automatic int lat_of(input int k);
      case (k)
         0: return 2;
         1: return 1;
         2: return 4;
         default: return 3;
      endcase
   endfunction

   function automatic logic [31:0] base_of(input int k);
      return (k == 2) ? 32'h40 : 32'h0;
   endfunction

   typedef struct {
      int          due;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mdl [N][DW];
   int          cur     = 0;
   int          cyc     = 0;
   int          n_chk   = 0;
   int          n_pass  = 0;
   bit          mon_en  = 1'b0;
   logic [31:0] last_rd = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s (inst %0d, cycle %0d): got %h, expected %h", tag, cur, cyc, got, exp);
   endtask

   // Reference: flat word array per instance, updated in acceptance order.
   task automatic model(input int k, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m,
                        output logic e, output logic [31:0] rd);
      logic [31:0] lm, off;
      int          idx;
      lm  = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
      off = a - base_of(k);
      e   = (r && w) || (a % 4 != 0) || (a < base_of(k)) || (off >= 32'(DW * 4));
      rd  = '0;
      if (!e) begin
         idx = int'(off / 4);
         if (w) mdl[k][idx] = (mdl[k][idx] & ~lm) | (d & lm);
         else   rd = mdl[k][idx] & lm;
      end
   endtask

   always @(negedge clk) begin
      if (mon_en && rst_n[cur]) begin
         if (q.size() > 0 && q[0].due == cyc) begin
            chk("resp_valid", 32'(valid[cur]), 32'd1);
            chk("resp_err", 32'(err[cur]), 32'(q[0].err));
            chk("resp_rdata", rdata[cur], q[0].rdata);
            last_rd = q[0].rdata;
            void'(q.pop_front());
         end else begin
            chk("idle_valid_err", {30'd0, err[cur], valid[cur]}, 32'd0);
            chk("hold_rdata", rdata[cur], last_rd);
         end
         chk("busy", 32'(busy[cur]), 32'(q.size() > 0 && q[0].due > cyc));
      end
   end

   task automatic issue(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input bit track = 1'b1);
      int          n_wait = 0;
      logic        e;
      logic [31:0] rd;
      exp_t        x;
      @(negedge clk);
      ren[cur] = r; wen[cur] = w; addr[cur] = a; wdata[cur] = d; mask[cur] = m;
      while (busy[cur] && n_wait < 30) begin
         @(negedge clk);
         n_wait++;
      end
      if (busy[cur]) begin
         chk("accept_timeout", 32'd1, 32'd0);
         return;
      end
      @(posedge clk);
      if (track) begin
         model(cur, r, w, a, d, m, e, rd);
         x.due = cyc + lat_of(cur);
         x.err = e;
         x.rdata = rd;
         q.push_back(x);
      end
   endtask

   task automatic quiet(input int n);
      @(negedge clk);
      ren[cur] = 1'b0; wen[cur] = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic fill();
      for (int i = 0; i < DW; i++) issue(1'b0, 1'b1, base_of(cur) + 32'(4 * i), $urandom, 4'hF);
      quiet(lat_of(cur) + 1);
   endtask

   task automatic random_run(input int n);
      logic [31:0] a;
      logic        r, w;
      int          s;
      for (int i = 0; i < n; i++) begin
         s = $urandom_range(0, 9);
         if (s == 0)      a = base_of(cur) + 32'($urandom_range(0, 80));
         else if (s == 1) a = $urandom;
         else             a = base_of(cur) + 32'(4 * $urandom_range(0, DW - 1));
         s = $urandom_range(0, 9);
         r = (s == 0) || (s > 4);
         w = (s <= 4);
         issue(r, w, a, $urandom, 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 3) == 0) quiet($urandom_range(0, 2));
      end
      quiet(lat_of(cur) + 3);
      chk("drain", 32'(q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < N; k++) begin
         rst_n[k] = 1'b0; ren[k] = 1'b0; wen[k] = 1'b0;
         addr[k] = '0; wdata[k] = '0; mask[k] = '0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < N; k++) begin
         cur = k;
         chk("reset_busy", 32'(busy[k]), 32'd0);
         chk("reset_valid", 32'(valid[k]), 32'd0);
         chk("reset_err", 32'(err[k]), 32'd0);
         chk("reset_rdata", rdata[k], 32'd0);
      end
      for (int k = 0; k < N; k++) rst_n[k] = 1'b1;

      // LATENCY=2: basic write/read, byte lanes, errors
      cur = 0; last_rd = '0; mon_en = 1'b1;
      fill();
      issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      issue(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
      quiet(3);
      chk("read_deadbeef", rdata[0], 32'hDEADBEEF);
      issue(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF);
      issue(1'b0, 1'b1, 32'h20, 32'hAA000000, 4'h8);
      issue(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
      quiet(3);
      chk("lane_full", rdata[0], 32'hAA223344);
      issue(1'b1, 1'b0, 32'h20, 32'h0, 4'hC);
      quiet(3);
      chk("lane_upper", rdata[0], 32'hAA220000);
      issue(1'b1, 1'b1, 32'h10, 32'h0, 4'hF);
      issue(1'b1, 1'b0, 32'h12, 32'h0, 4'hF);
      issue(1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
      issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      issue(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
      quiet(3);
      chk("err_unchanged", rdata[0], 32'hDEADBEEF);
      random_run(60);

      // LATENCY=1: back-to-back, never busy
      cur = 1; last_rd = '0;
      fill();
      issue(1'b0, 1'b1, 32'h0, 32'h5, 4'hF);
      issue(1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
      quiet(2);
      chk("b2b_read", rdata[1], 32'h5);
      random_run(60);

      // LATENCY=4, base 0x40: address change during WAIT, held request, below-base errors
      cur = 2; last_rd = '0;
      fill();
      issue(1'b1, 1'b0, 32'h44, 32'h0, 4'hF);
      issue(1'b1, 1'b0, 32'h48, 32'h0, 4'hF);
      issue(1'b1, 1'b0, 32'h3C, 32'h0, 4'hF);
      issue(1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 4'hF);
      quiet(6);
      random_run(60);

      // LATENCY=3: reset while a write is pending
      cur = 3; last_rd = '0;
      fill();
      issue(1'b0, 1'b1, 32'h8, 32'h0, 4'hF);
      quiet(4);
      mon_en = 1'b0;
      issue(1'b0, 1'b1, 32'h8, 32'h77, 4'hF, 1'b0);
      @(negedge clk);
      rst_n[3] = 1'b0; ren[3] = 1'b0; wen[3] = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy[3]), 32'd0);
      chk("midrst_valid", 32'(valid[3]), 32'd0);
      chk("midrst_err", 32'(err[3]), 32'd0);
      chk("midrst_rdata", rdata[3], 32'd0);
      @(negedge clk);
      rst_n[3] = 1'b1;
      last_rd = '0;
      mon_en = 1'b1;
      quiet(5);
      issue(1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
      quiet(4);
      chk("rst_write_lost", rdata[3], 32'h0);
      random_run(60);

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
